// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC pipeline: mode encodings, arctangent table
// scaled to an arbitrary phase width, and the quarter-turn helper.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // atan(2^-i) with a full circle of 2^32, rounded to nearest.
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  return 32'h2000_0000;
            1:  return 32'h12E4_051E;
            2:  return 32'h09FB_385B;
            3:  return 32'h0511_11D4;
            4:  return 32'h028B_0D43;
            5:  return 32'h0145_D7E1;
            6:  return 32'h00A2_F61E;
            7:  return 32'h0051_7C55;
            8:  return 32'h0028_BE53;
            9:  return 32'h0014_5F2F;
            10: return 32'h000A_2F98;
            11: return 32'h0005_17CC;
            12: return 32'h0002_8BE6;
            13: return 32'h0001_45F3;
            14: return 32'h0000_A2FA;
            15: return 32'h0000_517D;
            16: return 32'h0000_28BE;
            17: return 32'h0000_145F;
            18: return 32'h0000_0A30;
            19: return 32'h0000_0518;
            20: return 32'h0000_028C;
            21: return 32'h0000_0146;
            22: return 32'h0000_00A3;
            23: return 32'h0000_0051;
            24: return 32'h0000_0029;
            25: return 32'h0000_0014;
            26: return 32'h0000_000A;
            27: return 32'h0000_0005;
            28: return 32'h0000_0003;
            29: return 32'h0000_0001;
            30: return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Arctangent of stage i for a phase word of zw bits (full circle = 2^zw).
    function automatic logic [31:0] atan_val(input int i, input int zw);
        logic [31:0] t;
        t = atan32(i);
        if (zw >= 32) return t;
        return (t + (32'd1 << (31 - zw))) >> (32 - zw);
    endfunction

    // 90 degrees for a phase word of zw bits.
    function automatic logic [31:0] quarter(input int zw);
        return 32'd1 << (zw - 2);
    endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// One registered CORDIC micro-rotation; valid and mode ride alongside the data.
module cordic_pipe_stage
    import cordic_pkg::*;
#(
    parameter int          W     = 18,
    parameter int          ZW    = 16,
    parameter int          SHIFT = 0,
    parameter logic [31:0] ATAN  = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 valid_i,
    input  logic                 mode_i,
    input  logic signed [W-1:0]  x_i,
    input  logic signed [W-1:0]  y_i,
    input  logic signed [ZW-1:0] z_i,
    output logic                 valid_o,
    output logic                 mode_o,
    output logic signed [W-1:0]  x_o,
    output logic signed [W-1:0]  y_o,
    output logic signed [ZW-1:0] z_o
);

    localparam logic signed [ZW-1:0] ATAN_Z = ATAN[ZW-1:0];

    logic signed [W-1:0]  x_sh, y_sh;
    logic                 dir_pos;
    logic signed [W-1:0]  x_d, y_d;
    logic signed [ZW-1:0] z_d;
    logic                 valid_q, mode_q;
    logic signed [W-1:0]  x_q, y_q;
    logic signed [ZW-1:0] z_q;

    assign x_sh = x_i >>> SHIFT;
    assign y_sh = y_i >>> SHIFT;

    // Rotation steers z toward 0, vectoring steers y toward 0.
    assign dir_pos = (mode_i == MODE_ROT) ? ~z_i[ZW-1] : y_i[W-1];

    // Micro-rotation by +/- atan(2^-SHIFT); all sums wrap.
    always_comb begin
        x_d = dir_pos ? (x_i - y_sh)   : (x_i + y_sh);
        y_d = dir_pos ? (y_i + x_sh)   : (y_i - x_sh);
        z_d = dir_pos ? (z_i - ATAN_Z) : (z_i + ATAN_Z);
    end

    // Stage register: reset clears everything, ce gates every update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else if (ce) begin
            valid_q <= valid_i;
            mode_q  <= mode_i;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: registered quadrant pre-rotation followed by STAGES
// micro-rotation stages. Gain (~1.6468) is left uncompensated.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int XY_WIDTH = 16,
    parameter int Z_WIDTH  = 16,
    parameter int STAGES   = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic                       mode_in,
    input  logic signed [XY_WIDTH-1:0] xin,
    input  logic signed [XY_WIDTH-1:0] yin,
    input  logic signed [Z_WIDTH-1:0]  zin,
    output logic                       out_valid,
    output logic signed [XY_WIDTH+1:0] xout,
    output logic signed [XY_WIDTH+1:0] yout,
    output logic signed [Z_WIDTH-1:0]  zout
);

    localparam int XW = XY_WIDTH + 2;
    localparam logic [Z_WIDTH-1:0] QTR = Z_WIDTH'(quarter(Z_WIDTH));

    logic signed [XW-1:0]      xe, ye;
    logic signed [XW-1:0]      x_d, y_d;
    logic signed [Z_WIDTH-1:0] z_d;
    logic                      valid_q, mode_q;
    logic signed [XW-1:0]      x_q, y_q;
    logic signed [Z_WIDTH-1:0] z_q;

    logic                      vs [STAGES+1];
    logic                      ms [STAGES+1];
    logic signed [XW-1:0]      xs [STAGES+1];
    logic signed [XW-1:0]      ys [STAGES+1];
    logic signed [Z_WIDTH-1:0] zs [STAGES+1];
    logic                      mode_unused;

    // Widen before any negation so the most negative input cannot overflow.
    assign xe = XW'(xin);
    assign ye = XW'(yin);

    // Quadrant pre-rotation by +/-90 deg so the stages only see +/-90 deg of work.
    always_comb begin
        x_d = xe;
        y_d = ye;
        z_d = zin;
        if (mode_in == MODE_ROT) begin
            if (!zin[Z_WIDTH-1] && zin[Z_WIDTH-2]) begin
                x_d = -ye;
                y_d = xe;
                z_d = zin - QTR;
            end else if (zin[Z_WIDTH-1] && !zin[Z_WIDTH-2]) begin
                x_d = ye;
                y_d = -xe;
                z_d = zin + QTR;
            end
        end else if (xe[XW-1]) begin
            if (!ye[XW-1]) begin
                x_d = ye;
                y_d = -xe;
                z_d = zin + QTR;
            end else begin
                x_d = -ye;
                y_d = xe;
                z_d = zin - QTR;
            end
        end
    end

    // Pre-rotation register, first of the STAGES+1 pipeline slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else if (ce) begin
            valid_q <= in_valid;
            mode_q  <= mode_in;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign vs[0] = valid_q;
    assign ms[0] = mode_q;
    assign xs[0] = x_q;
    assign ys[0] = y_q;
    assign zs[0] = z_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        cordic_pipe_stage #(
            .W     (XW),
            .ZW    (Z_WIDTH),
            .SHIFT (g),
            .ATAN  (atan_val(g, Z_WIDTH))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .valid_i (vs[g]),
            .mode_i  (ms[g]),
            .x_i     (xs[g]),
            .y_i     (ys[g]),
            .z_i     (zs[g]),
            .valid_o (vs[g+1]),
            .mode_o  (ms[g+1]),
            .x_o     (xs[g+1]),
            .y_o     (ys[g+1]),
            .z_o     (zs[g+1])
        );
    end

    // The mode of the final stage has no consumer.
    assign mode_unused = ms[STAGES];

    assign out_valid = vs[STAGES];
    assign xout      = xs[STAGES];
    assign yout      = ys[STAGES];
    assign zout      = zs[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe: a slot-level pipeline model driven by an
// integer-arithmetic CORDIC reference, plus directed ideal-value checks.
module tb_cordic_pipe;

    localparam int LAT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce = 1'b0;
    logic in_valid = 1'b0;
    logic mode_in = 1'b0;
    logic signed [15:0] xin = '0;
    logic signed [15:0] yin = '0;
    logic signed [15:0] zin = '0;
    logic               out_valid;
    logic signed [17:0] xout, yout;
    logic signed [15:0] zout;

    int checks = 0;
    int failures = 0;
    int cap_cnt = 0;
    int out_cnt = 0;

    int atan_t [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

    int mv [LAT];
    int mx [LAT];
    int my [LAT];
    int mz [LAT];

    always #5 clk = ~clk;

    cordic_pipe #(.XY_WIDTH(16), .Z_WIDTH(16), .STAGES(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .mode_in   (mode_in),
        .xin       (xin),
        .yin       (yin),
        .zin       (zin),
        .out_valid (out_valid),
        .xout      (xout),
        .yout      (yout),
        .zout      (zout)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    function automatic int w18(input int v);
        return (v <<< 14) >>> 14;
    endfunction

    function automatic int w16(input int v);
        return (v <<< 16) >>> 16;
    endfunction

    // Reference CORDIC in plain integer arithmetic: 90-degree fold, then 14 micro-rotations.
    function automatic void model(input int mode, input int x, input int y, input int z,
                                  output int ox, output int oy, output int oz);
        int xx, yy, zz, t, d, nx, ny;
        xx = x; yy = y; zz = z;
        if (mode == 0) begin
            if (zz >= 16384) begin t = xx; xx = -yy; yy = t; zz = zz - 16384; end
            else if (zz < -16384) begin t = xx; xx = yy; yy = -t; zz = zz + 16384; end
        end else if (xx < 0) begin
            if (yy >= 0) begin t = xx; xx = yy; yy = -t; zz = zz + 16384; end
            else begin t = xx; xx = -yy; yy = t; zz = zz - 16384; end
        end
        for (int i = 0; i < 14; i++) begin
            if (mode == 0) d = (zz >= 0) ? 1 : -1;
            else           d = (yy < 0) ? 1 : -1;
            nx = xx - d * (yy >>> i);
            ny = yy + d * (xx >>> i);
            zz = w16(zz - d * atan_t[i]);
            xx = w18(nx);
            yy = w18(ny);
        end
        ox = xx; oy = yy; oz = zz;
    endfunction

    // Expected-result pipeline: one slot per ce-qualified edge.
    initial begin
        for (int k = 0; k < LAT; k++) begin mv[k] = 0; mx[k] = 0; my[k] = 0; mz[k] = 0; end
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int k = 0; k < LAT; k++) begin mv[k] = 0; mx[k] = 0; my[k] = 0; mz[k] = 0; end
            end else if (ce) begin
                if (out_valid) out_cnt++;
                for (int k = LAT - 1; k > 0; k--) begin
                    mv[k] = mv[k-1]; mx[k] = mx[k-1]; my[k] = my[k-1]; mz[k] = mz[k-1];
                end
                model(int'(mode_in), int'(xin), int'(yin), int'(zin), mx[0], my[0], mz[0]);
                mv[0] = int'(in_valid);
                if (in_valid) cap_cnt++;
            end
        end
    end

    // Output monitor, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", int'(out_valid), mv[LAT-1], 0);
            if (mv[LAT-1] != 0) begin
                check("model_x", int'(xout), mx[LAT-1], 0);
                check("model_y", int'(yout), my[LAT-1], 0);
                check("model_z", int'(zout), mz[LAT-1], 0);
            end
        end
    end

    task automatic send(input int mode, input int x, input int y, input int z);
        @(posedge clk); #1;
        mode_in = mode[0]; xin = 16'(x); yin = 16'(y); zin = 16'(z); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts ce edges from the capture edge until out_valid shows; leaves us at a negedge.
    task automatic wait_out(input string tag, output int n);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!out_valid) check({tag, "_timeout"}, 0, 1, 0);
    endtask

    task automatic directed(input string tag, input int mode, input int x, input int y, input int z,
                            input int ex, input int ey, input int ez, input bit z_unsigned);
        int n;
        send(mode, x, y, z);
        wait_out(tag, n);
        check({tag, "_lat"}, n, LAT, 0);
        check({tag, "_x"}, int'(xout), ex, 3);
        check({tag, "_y"}, int'(yout), ey, 3);
        if (z_unsigned) check({tag, "_z"}, int'($unsigned(zout)), ez, 3);
        else            check({tag, "_z"}, int'(zout), ez, 3);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int got;
        int cx [2] = '{-32768, 32767};
        int cz [5] = '{0, 16384, -16384, -32768, 8000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0, 0);
        check("rst_x", int'(xout), 0, 0);
        check("rst_y", int'(yout), 0, 0);
        check("rst_z", int'(zout), 0, 0);
        rst = 1'b1;
        ce  = 1'b1;

        directed("rot0",   0,  10000,     0,      0,  16468,     0,      0, 1'b0);
        directed("rot90",  0,  10000,     0,  16384,      0, 16468,      0, 1'b0);
        directed("rot180", 0,  10000,     0, -32768, -16468,     0,      0, 1'b0);
        directed("vec45",  1,  10000, 10000,      0,  23289,     0,   8192, 1'b0);
        directed("vec180", 1, -10000,     0,      0,  16468,     0, 32768, 1'b1);
        directed("vec_corner", 1, -32768, -32768, 0, 76313,   0, -24576, 1'b0);

        // Mixed-mode stream with ce pattern 1,0,0,1.
        repeat (LAT + 2) @(posedge clk);
        #1;
        cap_cnt = 0;
        out_cnt = 0;
        got = 0;
        for (int c = 0; got < 20 && c < 200; c++) begin
            ce = (c % 4 == 0) || (c % 4 == 3);
            in_valid = 1'b1;
            mode_in = 1'($urandom_range(0, 1));
            xin = 16'($urandom);
            yin = 16'($urandom);
            zin = 16'($urandom);
            if (ce) got++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ce = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("stream_out_count", out_cnt, 20, 0);

        // Reset while the pipe is full of valid samples.
        for (int k = 0; k < 18; k++) begin
            in_valid = 1'b1;
            mode_in = 1'($urandom_range(0, 1));
            xin = 16'($urandom);
            yin = 16'($urandom);
            zin = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", int'(out_valid), 1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", int'(out_valid), 0, 0);
        check("post_rst_x", int'(xout), 0, 0);
        check("post_rst_y", int'(yout), 0, 0);
        check("post_rst_z", int'(zout), 0, 0);
        send(0, 12345, -6789, 20000);
        wait_out("post_rst", n);
        check("post_rst_lat", n, LAT, 0);

        // Corner magnitudes in both modes across all quadrants.
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    for (int q = 0; q < 5; q++) begin
                        in_valid = 1'b1;
                        mode_in = m[0];
                        xin = 16'(cx[a]);
                        yin = 16'(cx[b]);
                        zin = 16'(cz[q]);
                        @(posedge clk); #1;
                    end
        in_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
